// File: rtl/obc_dft_pkg.sv
// Shared widths and signed word types for the OBC DFT datapath (ROM, shift-accumulator, bin assembly).
// Latency: n/a (package only).
// Backpressure: n/a.
package obc_dft_pkg;

  localparam int DATA_W  = 16;               // input sample width = slices per frame
  localparam int ROM_W   = 32;               // ROM word width, signed Q11.21
  localparam int FRAC_W  = 21;               // fractional bits of ROM words and results
  localparam int NUM_ROM = 8;                // ROM partial words per slice
  localparam int SUM_W   = ROM_W + 3;        // exact width of an 8-word sum
  localparam int ACC_W   = ROM_W + 3 + DATA_W;
  localparam int CNT_W   = $clog2(DATA_W);

  typedef logic signed [ROM_W-1:0] rom_word_t;
  typedef logic signed [SUM_W-1:0] sum_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic sum_t sext_rom(input rom_word_t w);
    return {{(SUM_W-ROM_W){w[ROM_W-1]}}, w};
  endfunction

  function automatic acc_t sext_sum(input sum_t s);
    return {{(ACC_W-SUM_W){s[SUM_W-1]}}, s};
  endfunction

  function automatic acc_t sext_off(input rom_word_t w);
    return {{(ACC_W-ROM_W){w[ROM_W-1]}}, w};
  endfunction

endpackage

// File: rtl/obc_adder_tree8.sv
// Sums eight signed ROM partial words and registers the exact ROM_W+3 result with valid/first/last sideband.
// Latency: 1 cycle from vld_i to vld_o.
// Backpressure: none; every valid input produces a registered output the next cycle.
// Ports: clk, rst (async, active-high); vld_i/first_i/last_i sideband in; rom_i[8] words;
//        sum_o registered sum; vld_o/first_o/last_o registered sideband.
module obc_adder_tree8
  import obc_dft_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      vld_i,
  input  logic      first_i,
  input  logic      last_i,
  input  rom_word_t rom_i [NUM_ROM],
  output sum_t      sum_o,
  output logic      vld_o,
  output logic      first_o,
  output logic      last_o
);

  sum_t l1 [4];
  sum_t l2 [2];
  sum_t sum_d;
  sum_t sum_q;
  logic vld_q;
  logic first_q;
  logic last_q;

  // Balanced tree; every operand is widened first so no level can overflow.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      l1[i] = sext_rom(rom_i[2*i]) + sext_rom(rom_i[2*i+1]);
    end
    for (int i = 0; i < 2; i++) begin
      l2[i] = l1[2*i] + l1[2*i+1];
    end
    sum_d = l2[0] + l2[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        sum_q   <= sum_d;
        first_q <= first_i;
        last_q  <= last_i;
      end
    end
  end

  assign sum_o   = sum_q;
  assign vld_o   = vld_q;
  assign first_o = first_q;
  assign last_o  = last_q;

endmodule

// File: rtl/obc_shift_accumulator.sv
// Shift-accumulates DATA_W bit-slice sums (sign slice first), adds the bin offset, emits one result per frame.
// Latency: out_valid in the 2nd cycle after the last slice's in_valid cycle.
// Backpressure: none; a slice is accepted every cycle in_valid is high (clr overrides in_valid).
// Ports: clk, rst (async, active-high), clr (sync abort), in_valid, rom0..rom7, offset;
//        out_valid (1-cycle pulse), out_data (ACC_W signed, held), busy (frame in flight).
module obc_shift_accumulator
  import obc_dft_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      in_valid,
  input  rom_word_t rom0,
  input  rom_word_t rom1,
  input  rom_word_t rom2,
  input  rom_word_t rom3,
  input  rom_word_t rom4,
  input  rom_word_t rom5,
  input  rom_word_t rom6,
  input  rom_word_t rom7,
  input  rom_word_t offset,
  output logic      out_valid,
  output acc_t      out_data,
  output logic      busy
);

  rom_word_t        rom_a [NUM_ROM];
  logic             accept;
  logic             first_slice;
  logic             last_slice;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  rom_word_t        off_q;
  rom_word_t        off_s1_q;
  sum_t             s1_sum;
  logic             s1_vld, s1_first, s1_last;
  logic             s1_go;
  acc_t             acc_d, acc_q;
  acc_t             out_data_q;
  logic             out_valid_q;
  logic             busy_d, busy_q;

  assign rom_a       = '{rom0, rom1, rom2, rom3, rom4, rom5, rom6, rom7};
  assign accept      = in_valid & ~clr;
  assign first_slice = (cnt_q == '0);
  assign last_slice  = (cnt_q == CNT_W'(DATA_W-1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)         cnt_d = '0;
    else if (accept) cnt_d = last_slice ? '0 : cnt_q + 1'b1;
  end

  obc_adder_tree8 u_tree (
    .clk     (clk),
    .rst     (rst),
    .vld_i   (accept),
    .first_i (first_slice),
    .last_i  (last_slice),
    .rom_i   (rom_a),
    .sum_o   (s1_sum),
    .vld_o   (s1_vld),
    .first_o (s1_first),
    .last_o  (s1_last)
  );

  // clr must also kill a slice already in stage 1, otherwise a partial frame could emit.
  assign s1_go = s1_vld & ~clr;

  // Sign slice carries negative weight; later slices are one bit less significant each.
  always_comb begin
    acc_d = s1_first ? -sext_sum(s1_sum) : (acc_q <<< 1) + sext_sum(s1_sum);
  end

  always_comb begin
    busy_d = busy_q;
    if (s1_go && s1_last)       busy_d = 1'b0;
    if (accept && first_slice)  busy_d = 1'b1;
    if (clr)                    busy_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      off_q       <= '0;
      off_s1_q    <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      if (accept && first_slice) off_q <= offset;
      // off_s1 travels with stage 1 so a back-to-back sign slice can overwrite off_q
      // while the previous frame's last slice still needs its own offset.
      if (accept) off_s1_q <= first_slice ? offset : off_q;
      if (s1_go) acc_q <= acc_d;
      if (s1_go && s1_last) out_data_q <= acc_d + sext_off(off_s1_q);
      out_valid_q <= s1_go & s1_last;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Directed bench for obc_shift_accumulator: hand-computed frame results, latency, clr and reset behaviour.
module tb_obc_shift_accumulator;

  logic               clk = 1'b0;
  logic               rst;
  logic               clr;
  logic               in_valid;
  logic signed [31:0] rom_v [8];
  logic signed [31:0] offset;
  logic               out_valid;
  logic signed [50:0] out_data;
  logic               busy;

  int     cyc = 0;
  int     last_cyc = 0;
  int     n_checks = 0;
  int     n_errors = 0;
  longint res_q [$];
  int     resc_q [$];
  longint exp_q [$];
  int     expc_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  obc_shift_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .rom0      (rom_v[0]),
    .rom1      (rom_v[1]),
    .rom2      (rom_v[2]),
    .rom3      (rom_v[3]),
    .rom4      (rom_v[4]),
    .rom5      (rom_v[5]),
    .rom6      (rom_v[6]),
    .rom7      (rom_v[7]),
    .offset    (offset),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (out_valid) begin
      res_q.push_back(longint'(out_data));
      resc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode: 0 all ones, 1 sign slice rom0=1 else zero, 2 all zero, 3 all 0x80000000, 4 random
  task automatic run_frame(input int mode, input logic signed [31:0] off,
                           input int nslices, input int gap_max);
    longint expv = 0;
    longint s;
    int     gap;
    for (int i = 0; i < nslices; i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) rom_v[j] = $urandom;
        offset = $urandom;
        @(posedge clk); #1;
      end
      for (int j = 0; j < 8; j++) begin
        case (mode)
          0:       rom_v[j] = 32'sd1;
          1:       rom_v[j] = (i == 0 && j == 0) ? 32'sd1 : 32'sd0;
          2:       rom_v[j] = 32'sd0;
          3:       rom_v[j] = 32'h8000_0000;
          default: rom_v[j] = $urandom;
        endcase
      end
      s = 0;
      for (int j = 0; j < 8; j++) s += longint'(rom_v[j]);
      expv += ((i == 0) ? -s : s) * (longint'(1) << (15 - i));
      // offset only matters on the sign slice; scribble it elsewhere
      offset   = (i == 0) ? off : $urandom;
      in_valid = 1'b1;
      last_cyc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    if (nslices == 16) begin
      exp_q.push_back(expv + longint'(off));
      expc_q.push_back(last_cyc + 2);
    end
  endtask

  task automatic check_results(input string tag);
    repeat (6) @(posedge clk);
    #1;
    chk({tag, "_count"}, res_q.size(), exp_q.size());
    while (res_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_data"}, res_q.pop_front(), exp_q.pop_front());
      chk({tag, "_lat"}, resc_q.pop_front(), expc_q.pop_front());
    end
    res_q.delete(); resc_q.delete(); exp_q.delete(); expc_q.delete();
    chk({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; offset = '0;
    for (int j = 0; j < 8; j++) rom_v[j] = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // all ones, zero offset -> -8
    run_frame(0, 32'sd0, 16, 0);
    check_results("ones");

    // lone sign bit -> -32768, then offset only -> 100
    run_frame(1, 32'sd0, 16, 0);
    check_results("sign_only");
    run_frame(2, 32'sd100, 16, 0);
    check_results("offset_only");

    // most negative ROM words everywhere -> +2^34
    run_frame(3, 32'sd0, 16, 0);
    check_results("min_rom");

    // two back-to-back random frames, then one with gaps
    run_frame(4, $urandom, 16, 0);
    run_frame(4, $urandom, 16, 0);
    run_frame(4, $urandom, 16, 3);
    check_results("random");

    // clr after 7 slices, then a clean frame
    run_frame(0, 32'sd55, 7, 0);
    chk("busy_mid_frame", busy, 1);
    clr = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_out_valid", out_valid, 0);
    run_frame(0, 32'sd0, 16, 0);
    check_results("after_clr");

    // asynchronous reset mid-frame, then a clean frame
    run_frame(4, 32'sd7, 5, 0);
    rst = 1'b1;
    #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(0, 32'sd0, 16, 0);
    check_results("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
